regfile_dump_reader: RTL and testbench

Debug read-out engine for the CPU's 32×32-bit register file. On a start request it walks one register-file read port over a configurable address range, captures each 32-bit word and streams it out as bytes, least significant byte first, on a valid/ready handshake. It owns one register-file read port, driving the address and sampling the combinational read data, and feeds the debug UART/trace path.

---
 rtl/regfile_dump_reader.sv | 111 +++++++++++
 tb/tb_regfile_dump_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks one register-file read port over
// [FIRST_REG, LAST_REG], captures each 32-bit word and streams it out as
// bytes (least significant first) on a valid/ready handshake.
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rda,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [4:0]  rda_n;
    logic [31:0] shift, shift_n;
    logic [1:0]  byte_cnt, byte_cnt_n;

    // State, address, captured word and byte counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rda      <= 5'd0;
            shift    <= 32'd0;
            byte_cnt <= 2'd0;
        end else begin
            state    <= state_n;
            rda      <= rda_n;
            shift    <= shift_n;
            byte_cnt <= byte_cnt_n;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE and
    // suppresses the transfer of any byte presented in the same cycle.
    always_comb begin
        state_n    = state;
        rda_n      = rda;
        shift_n    = shift;
        byte_cnt_n = byte_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    rda_n   = FIRST_A;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    // The word is frozen here; later register writes do not
                    // disturb the bytes still to be sent.
                    shift_n    = rd;
                    byte_cnt_n = 2'd0;
                    state_n    = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (out_ready) begin
                    if (byte_cnt != 2'd3) begin
                        shift_n    = shift >> 8;
                        byte_cnt_n = byte_cnt + 2'd1;
                    end else if (rda == LAST_A) begin
                        state_n = S_DONE;
                    end else begin
                        rda_n   = rda + 5'd1;
                        state_n = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so out_ready and rd
    // have no combinational path to any output.
    always_comb begin
        out_valid = (state == S_SEND);
        out_data  = shift[7:0];
        out_last  = (state == S_SEND) && (byte_cnt == 2'd3) && (rda == LAST_A);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader: a full-range instance and a
// single-register instance share a behavioural register-file model; the
// expected byte stream is derived from a snapshot of that model.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        ready;
    logic        sel;
    logic [31:0] regs [32];

    logic [4:0]  rda0, rda1;
    logic [31:0] rd0, rd1;
    logic        v0, v1, l0, l1, b0, b1, d0, d1;
    logic [7:0]  dat0, dat1;
    logic        start0, start1;

    logic        o_valid, o_last, o_busy, o_done;
    logic [7:0]  o_data;
    logic [4:0]  o_rda;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rd0    = regs[rda0];
    assign rd1    = regs[rda1];
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    assign o_valid = sel ? v1   : v0;
    assign o_data  = sel ? dat1 : dat0;
    assign o_last  = sel ? l1   : l0;
    assign o_busy  = sel ? b1   : b0;
    assign o_done  = sel ? d1   : d0;
    assign o_rda   = sel ? rda1 : rda0;

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .reset(reset), .start(start0), .abort(abort),
        .rda(rda0), .rd(rd0), .out_valid(v0), .out_ready(ready),
        .out_data(dat0), .out_last(l0), .busy(b0), .done(d0)
    );

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .rda(rda1), .rd(rd1), .out_valid(v1), .out_ready(ready),
        .out_data(dat1), .out_last(l1), .busy(b1), .done(d1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload_scaled();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
    endtask

    // Runs one dump on the selected instance. k counts rising edges after
    // the edge that samples start (k=0 is the cycle after E0); a transfer
    // seen at the negedge after E_k happens on E_(k+1).
    task automatic run_dump(input int ready_pct, input int abort_idx, input int write_idx,
                            input bit spam, output int n_bytes, output int done_cnt,
                            output int done_k, output int fall_k, output int last_k);
        logic [7:0] exp_q [$];
        int         first_r, last_r;
        bit         held, fin, aborted;
        logic [7:0] held_data;
        first_r = sel ? 5 : 0;
        last_r  = sel ? 5 : 31;
        for (int r = first_r; r <= last_r; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
        n_bytes = 0; done_cnt = 0; done_k = -1; fall_k = -1; last_k = -1;
        held = 0; fin = 0; aborted = 0; held_data = 8'd0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (spam && o_valid) start = 1'($urandom_range(0, 1));
            if (k == 0) begin
                check("load_valid", o_valid, 0);
                check("load_busy", o_busy, 1);
            end
            if (sel) check("rda_fixed", o_rda, 5);
            if (o_done) begin
                done_cnt++;
                done_k = k;
            end
            if (k > 0 && !o_busy) begin
                fall_k = k;
                fin    = 1;
            end else begin
                if (held && o_valid) check("stable", o_data, held_data);
                ready = ($urandom_range(0, 99) < ready_pct);
                if (o_valid && n_bytes == abort_idx) begin
                    abort   = 1'b1;
                    aborted = 1;
                    fin     = 1;
                end else if (o_valid && ready) begin
                    check("byte", o_data, exp_q[n_bytes]);
                    check("last", o_last, 32'(n_bytes == exp_q.size() - 1));
                    n_bytes++;
                    last_k = k + 1;
                    if (n_bytes - 1 == write_idx) regs[7] = 32'h1234_5678;
                end
                held      = o_valid && !ready;
                held_data = o_data;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            check("abort_valid", o_valid, 0);
            check("abort_busy", o_busy, 0);
            check("abort_done", o_done, 0);
        end else if (!fin) begin
            check("timeout", 1, 0);
        end
    endtask

    int nb, dc, dk, fk, lk;

    initial begin
        sel = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        preload_scaled();
        reset = 1'b1;
        #12;
        check("rst_valid", v0, 0);
        check("rst_data", dat0, 0);
        check("rst_last", l0, 0);
        check("rst_busy", b0, 0);
        check("rst_done", d0, 0);
        check("rst_rda", rda0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full dump, ready always high, exact latency.
        run_dump(100, -1, -1, 0, nb, dc, dk, fk, lk);
        check("full_bytes", nb, 128);
        check("full_done_cnt", dc, 1);
        check("full_done_k", dk, 160);
        check("full_last_k", lk, 160);
        check("full_busy_fall", fk, 161);

        // Single register dump.
        sel = 1'b1;
        regs[5] = 32'hDEAD_BEEF;
        run_dump(100, -1, -1, 0, nb, dc, dk, fk, lk);
        check("one_bytes", nb, 4);
        check("one_done_cnt", dc, 1);
        check("one_done_k", dk, 5);
        check("one_busy_fall", fk, 6);
        sel = 1'b0;

        // Random back-pressure.
        preload_scaled();
        run_dump(50, -1, -1, 0, nb, dc, dk, fk, lk);
        check("bp_bytes", nb, 128);
        check("bp_done_cnt", dc, 1);

        // Abort on the second byte of register 3, then restart.
        run_dump(100, 13, -1, 0, nb, dc, dk, fk, lk);
        check("abort_bytes", nb, 13);
        check("abort_done_cnt", dc, 0);
        run_dump(100, -1, -1, 0, nb, dc, dk, fk, lk);
        check("restart_bytes", nb, 128);
        check("restart_done_cnt", dc, 1);

        // Asynchronous reset in the middle of SEND.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", b0, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", v0, 0);
        check("mid_rst_data", dat0, 0);
        check("mid_rst_last", l0, 0);
        check("mid_rst_busy", b0, 0);
        check("mid_rst_done", d0, 0);
        check("mid_rst_rda", rda0, 0);
        @(negedge clk);
        reset = 1'b0;

        // start pulses while busy must be ignored.
        run_dump(100, -1, -1, 1, nb, dc, dk, fk, lk);
        check("spam_bytes", nb, 128);
        check("spam_done_cnt", dc, 1);
        repeat (4) begin
            @(negedge clk);
            check("spam_idle", b0, 0);
        end

        // Write to register 7 while its word is being sent.
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        run_dump(100, -1, 28, 0, nb, dc, dk, fk, lk);
        check("wr_bytes", nb, 128);
        check("wr_done_cnt", dc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
